pattern_generator: RTL and testbench

Serial transmitter for the "0110" framing pattern counted by the bitsolver pattern-recognition receiver. On a start request it drives N back-to-back copies of 0110 onto a one-bit line, with a programmable run of zero filler bits between copies. The encoding guarantees that a receiver sampling the same clock counts exactly N patterns. It sits on the stimulus/transmit side of the bitsolver loopback, with dout wired straight to the receiver's din.

---
 rtl/pattern_generator.sv | 118 +++++++++++
 tb/tb_pattern_generator.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/pattern_generator.sv
// Serial "0110" pattern transmitter: sends num_pat back-to-back patterns with
// gap zero-filler bits between them, ending every job with a one-cycle done pulse.
module pattern_generator #(
  parameter int CNT_W = 16,
  parameter int GAP_W = 4
) (
  input  logic             clk,
  input  logic             srst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] num_pat,
  input  logic [GAP_W-1:0] gap,
  input  logic             abort,
  output logic             dout,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] sent
);

  typedef enum logic [2:0] {
    IDLE, BIT0, BIT1, BIT2, BIT3, GAP, FIN
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] rem_q, rem_d;        // patterns still to send after the current one
  logic [GAP_W-1:0] gap_lat_q, gap_lat_d;
  logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
  logic [CNT_W-1:0] sent_q, sent_d;
  logic             abort_pend_q, abort_pend_d;
  logic             dout_q, dout_d;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge srst_n) begin
    if (!srst_n) begin
      state_q      <= IDLE;
      rem_q        <= '0;
      gap_lat_q    <= '0;
      gap_cnt_q    <= '0;
      sent_q       <= '0;
      abort_pend_q <= 1'b0;
      dout_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      rem_q        <= rem_d;
      gap_lat_q    <= gap_lat_d;
      gap_cnt_q    <= gap_cnt_d;
      sent_q       <= sent_d;
      abort_pend_q <= abort_pend_d;
      dout_q       <= dout_d;
    end
  end

  // NOTE: every variable gets a hold default before the case so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d      = state_q;
    rem_d        = rem_q;
    gap_lat_d    = gap_lat_q;
    gap_cnt_d    = gap_cnt_q;
    sent_d       = sent_q;
    abort_pend_d = abort_pend_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          gap_lat_d    = gap;
          sent_d       = '0;
          abort_pend_d = 1'b0;
          if (num_pat == '0) begin
            rem_d   = '0;
            state_d = FIN;
          end else begin
            rem_d   = num_pat - CNT_W'(1);
            state_d = BIT0;
          end
        end
      end
      BIT0, BIT1, BIT2: begin
        // An abort here is only remembered; cutting the pattern short would
        // leave a "011" that the receiver counts as a spurious match.
        if (abort) abort_pend_d = 1'b1;
        state_d = state_e'(state_q + 3'd1);
      end
      BIT3: begin
        if (sent_q != '1) sent_d = sent_q + CNT_W'(1);
        if (rem_q == '0 || abort || abort_pend_q) begin
          state_d = FIN;
        end else begin
          rem_d = rem_q - CNT_W'(1);
          if (gap_lat_q == '0) begin
            state_d = BIT0;
          end else begin
            gap_cnt_d = gap_lat_q - GAP_W'(1);
            state_d   = GAP;
          end
        end
      end
      GAP: begin
        if (abort)                  state_d = FIN;
        else if (gap_cnt_q == '0)   state_d = BIT0;
        else                        gap_cnt_d = gap_cnt_q - GAP_W'(1);
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // dout is registered from the next state so it lines up with state_q.
  always_comb begin
    dout_d = (state_d == BIT1) || (state_d == BIT2);
    busy   = (state_q == BIT0) || (state_q == BIT1) || (state_q == BIT2) ||
             (state_q == BIT3) || (state_q == GAP);
    done   = (state_q == FIN);
  end

  assign dout = dout_q;
  assign sent = sent_q;

endmodule

// File: tb/tb_pattern_generator.sv
// Directed bench for pattern_generator with a sliding-window "0110" receiver model.
module tb_pattern_generator;

  localparam int CNT_W = 16;
  localparam int GAP_W = 4;

  logic             clk;
  logic             srst_n;
  logic             start;
  logic [CNT_W-1:0] num_pat;
  logic [GAP_W-1:0] gap;
  logic             abort;
  logic             dout;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] sent;

  int total = 0;
  int bad   = 0;

  // Results of the last collected job.
  logic [63:0] c_bits;
  int          c_busy;
  int          c_done_at;
  int          c_stray;

  // Receiver model: counts every "0110" seen on dout, one bit per cycle.
  logic [3:0] rx_win;
  int         rx_cnt;
  int         rx_base;

  pattern_generator #(.CNT_W(CNT_W), .GAP_W(GAP_W)) dut (
    .clk     (clk),
    .srst_n  (srst_n),
    .start   (start),
    .num_pat (num_pat),
    .gap     (gap),
    .abort   (abort),
    .dout    (dout),
    .busy    (busy),
    .done    (done),
    .sent    (sent)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk or negedge srst_n) begin
    if (!srst_n) begin
      rx_win = 4'b1111;
      rx_cnt = 0;
    end else begin
      rx_win = {rx_win[2:0], dout};
      if (rx_win == 4'b0110) rx_cnt = rx_cnt + 1;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Runs one job whose start was set up in the current cycle T; cycle i is T+i.
  task automatic collect(input int restart_at, input int ab_from, input int ab_to);
    c_bits    = '0;
    c_busy    = 0;
    c_done_at = -1;
    c_stray   = 0;
    for (int i = 1; i <= 200; i++) begin
      step();
      start = (i == restart_at);
      if (i == restart_at) num_pat = 16'd7;
      abort = (i >= ab_from) && (i <= ab_to);
      if (busy) begin
        c_bits = {c_bits[62:0], dout};
        c_busy++;
      end else if (dout) begin
        c_stray++;
      end
      if (done) begin
        c_done_at = i;
        break;
      end
    end
    start = 1'b0;
    abort = 1'b0;
    step();
  endtask

  task automatic launch(input int n, input int g);
    num_pat = CNT_W'(n);
    gap     = GAP_W'(g);
    start   = 1'b1;
    rx_base = rx_cnt;
  endtask

  initial begin
    srst_n  = 1'b0;
    start   = 1'b0;
    num_pat = '0;
    gap     = '0;
    abort   = 1'b0;
    #12;
    check("rst_dout", 64'(dout), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_sent", 64'(sent), 64'd0);
    step();
    srst_n = 1'b1;
    step();
    step();

    // Single pattern, no gap.
    launch(1, 0);
    collect(0, 1000, -1);
    check("n1_bits", c_bits, 64'h6);
    check("n1_busy", 64'(c_busy), 64'd4);
    check("n1_done_at", 64'(c_done_at), 64'd5);
    check("n1_sent", 64'(sent), 64'd1);
    check("n1_rx", 64'(rx_cnt - rx_base), 64'd1);

    // Three patterns with two filler zeros.
    launch(3, 2);
    collect(0, 1000, -1);
    check("n3g2_bits", c_bits, 64'h6186);
    check("n3g2_busy", 64'(c_busy), 64'd16);
    check("n3g2_done_at", 64'(c_done_at), 64'd17);
    check("n3g2_sent", 64'(sent), 64'd3);
    check("n3g2_rx", 64'(rx_cnt - rx_base), 64'd3);
    check("n3g2_stray", 64'(c_stray), 64'd0);

    // Zero patterns: immediate done, no bits.
    launch(0, 3);
    collect(0, 1000, -1);
    check("n0_done_at", 64'(c_done_at), 64'd1);
    check("n0_busy", 64'(c_busy), 64'd0);
    check("n0_stray", 64'(c_stray), 64'd0);
    check("n0_sent", 64'(sent), 64'd0);

    // Abort pulsed during BIT1 of pattern 4 (cycle 14).
    launch(10, 0);
    collect(0, 14, 14);
    check("abort_bits", c_bits, 64'h6666);
    check("abort_busy", 64'(c_busy), 64'd16);
    check("abort_done_at", 64'(c_done_at), 64'd17);
    check("abort_sent", 64'(sent), 64'd4);
    check("abort_rx", 64'(rx_cnt - rx_base), 64'd4);

    // Abort in the second GAP cycle ends the job at once.
    launch(3, 3);
    collect(0, 6, 6);
    check("gapab_bits", c_bits, 64'h18);
    check("gapab_busy", 64'(c_busy), 64'd6);
    check("gapab_done_at", 64'(c_done_at), 64'd7);
    check("gapab_sent", 64'(sent), 64'd1);

    // Start with abort already held: first pattern still goes out in full.
    launch(2, 0);
    abort = 1'b1;
    collect(0, 1, 200);
    check("stab_bits", c_bits, 64'h6);
    check("stab_busy", 64'(c_busy), 64'd4);
    check("stab_sent", 64'(sent), 64'd1);
    check("stab_rx", 64'(rx_cnt - rx_base), 64'd1);

    // Second start mid-job is ignored.
    launch(2, 1);
    collect(3, 1000, -1);
    check("restart_bits", c_bits, 64'h0C6);
    check("restart_busy", 64'(c_busy), 64'd9);
    check("restart_done_at", 64'(c_done_at), 64'd10);
    check("restart_sent", 64'(sent), 64'd2);

    // Asynchronous reset during BIT2 of pattern 2 (cycle 7).
    launch(2, 0);
    for (int i = 1; i <= 7; i++) begin
      step();
      start = 1'b0;
    end
    check("prerst_dout", 64'(dout), 64'd1);
    check("prerst_sent", 64'(sent), 64'd1);
    #1;
    srst_n = 1'b0;
    #1;
    check("midrst_dout", 64'(dout), 64'd0);
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_sent", 64'(sent), 64'd0);
    step();
    step();
    srst_n = 1'b1;
    step();

    launch(1, 0);
    collect(0, 1000, -1);
    check("post_bits", c_bits, 64'h6);
    check("post_busy", 64'(c_busy), 64'd4);
    check("post_done_at", 64'(c_done_at), 64'd5);
    check("post_sent", 64'(sent), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
